xbar_ctrl_pipe: RTL and testbench
=================================

Name: xbar_ctrl_pipe

Overview:
Parametrised, registered crossbar controller for the bufferless router datapath. Accepts one allocation matrix per cycle from the port allocator. For each input it produces an output-select code, and for each output an input-select code with a valid bit. The block detects illegal allocations (multi-hot rows, two inputs mapped to one output) and keeps saturating per-output traversal counters. Selects feed the crossbar mux stage through a single valid/ready pipeline register.

Parameters:
NUM_PORT, 5, number of router ports (4-LOCAL, 3-N, 2-S, 1-E, 0-W for the default mesh).
LOG_NUM_PORT, 3, width of a select code; must satisfy NUM_PORT < 2**LOG_NUM_PORT.
CNT_W, 16, width of each traversal counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
alloc_valid  input  1  alloc_vector carries a valid allocation this cycle.
alloc_ready  output  1  block can accept; equals (~out_valid | out_ready).
alloc_vector  input  NUM_PORT*NUM_PORT  row j at bits [j*NUM_PORT +: NUM_PORT] is input j's one-hot output grant; bit i set means output i.
out_valid  output  1  registered selects are valid.
out_ready  input  1  crossbar consumes the selects this cycle.
out_sel_vector  output  NUM_PORT*LOG_NUM_PORT  field j is the output index for input j, or IDLE.
in_sel_vector  output  NUM_PORT*LOG_NUM_PORT  field i is the input index driving output i, or IDLE.
in_sel_valid  output  NUM_PORT  bit i set when output i is driven.
conflict  output  1  registered allocation was illegal.
conflict_sticky  output  1  latched illegal-allocation flag.
err_clear  input  1  clears conflict_sticky.
count_clear  input  1  clears all traversal counters.
trav_count_vector  output  NUM_PORT*CNT_W  field i counts accepted traversals to output i.

Behaviour:
- IDLE code is all ones ({LOG_NUM_PORT{1'b1}}).
- Accept occurs when alloc_valid & alloc_ready. Release occurs when out_valid & out_ready.
- Latency is exactly 1 cycle from accept to out_valid with the decoded selects.
- Pipeline register behaviour:
  - On accept: load all decoded fields; out_valid <= 1.
  - On release without accept: out_valid <= 0; select fields hold their last values.
  - Otherwise: all registered outputs hold.
  - Accept and release in the same cycle: new data is loaded back-to-back with no bubble.
- Row decode (input j):
  - Zero bits set: out_sel field = IDLE.
  - One or more bits set: field = index of the lowest set bit.
  - More than one bit set is a row error.
- Column decode (output i):
  - Candidates are the inputs whose decoded out_sel equals i.
  - The lowest-index candidate wins: in_sel field = its index, in_sel_valid[i] = 1.
  - No candidates: field = IDLE, in_sel_valid[i] = 0. Stale values are never held.
  - More than one candidate is a column error.
- conflict is registered alongside the selects and equals (any row error | any column error) of the accepted matrix.
- conflict_sticky:
  - Set on accept of an erroneous matrix.
  - Cleared by err_clear.
  - A set in the same cycle as err_clear wins.
- Traversal counters: on accept, counter i increments by 1 if in_sel_valid[i] of the decoded matrix is 1.
  - Only the winning input is counted; losers in a column conflict are not.
  - Counters saturate at 2**CNT_W-1.
  - count_clear forces all counters to 0 and wins over a simultaneous increment.
- Reset values:
  - out_valid = 0, conflict = 0, conflict_sticky = 0.
  - out_sel and in_sel fields = IDLE; in_sel_valid = 0.
  - All counters = 0; alloc_ready = 1.
- Reset asserted mid-transfer discards any held entry; accepts presented during reset are ignored.
- Decode is purely combinational from alloc_vector into the register. There is no combinational path from alloc_vector to outputs, and alloc_ready depends only on out_valid and out_ready.

Test Plan:
1. Reset, then hold alloc_valid=0 -> out_valid=0, all select fields = 3'b111, in_sel_valid=0, counters=0, alloc_ready=1.
2. NUM_PORT=5, out_ready=1. Rows 0..4 = 00010, 00100, 01000, 10000, 00001 -> next cycle out_sel={0,4,3,2,1} for inputs 4..0; in_sel[1]=0, in_sel[2]=1, in_sel[3]=2, in_sel[4]=3, in_sel[0]=4; in_sel_valid=11111; conflict=0; each counter=1.
3. Rows 1 and 3 both = 00100, others 0 -> in_sel[2]=1, in_sel_valid=00100, conflict=1, conflict_sticky=1. Then pulse err_clear with no new error -> sticky 0. Error and err_clear in the same cycle -> sticky 1.
4. Row 0 = 00110 -> out_sel[0]=1, conflict=1. Then hold out_ready=0 for 3 cycles with new allocs presented -> alloc_ready=0, outputs stable, counters unchanged. Release: next alloc is loaded with no bubble.
5. CNT_W=4, 20 accepts with output 2 driven -> counter 2 saturates at 15. Assert count_clear together with an accept -> all counters 0.
6. Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, selects IDLE, sticky 0.

Source files
------------

// File: rtl/xbar_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// xbar_ctrl_pipe_if : allocation-in / select-out bundle of the crossbar control
// Rev 1.0
// ============================================================================
interface xbar_ctrl_pipe_if #(
  parameter int NUM_PORT     = 5,
  parameter int LOG_NUM_PORT = 3,
  parameter int CNT_W        = 16
) ();
  logic                             alloc_valid;
  logic                             alloc_ready;
  logic [NUM_PORT*NUM_PORT-1:0]     alloc_vector;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_PORT*LOG_NUM_PORT-1:0] out_sel_vector;
  logic [NUM_PORT*LOG_NUM_PORT-1:0] in_sel_vector;
  logic [NUM_PORT-1:0]              in_sel_valid;
  logic                             conflict;
  logic                             conflict_sticky;
  logic                             err_clear;
  logic                             count_clear;
  logic [NUM_PORT*CNT_W-1:0]        trav_count_vector;

  modport master (
    output alloc_valid, alloc_vector, out_ready, err_clear, count_clear,
    input  alloc_ready, out_valid, out_sel_vector, in_sel_vector, in_sel_valid,
           conflict, conflict_sticky, trav_count_vector
  );

  modport slave (
    input  alloc_valid, alloc_vector, out_ready, err_clear, count_clear,
    output alloc_ready, out_valid, out_sel_vector, in_sel_vector, in_sel_valid,
           conflict, conflict_sticky, trav_count_vector
  );
endinterface
`default_nettype wire

// File: rtl/xbar_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// xbar_ctrl_pipe : allocation-matrix decode into registered crossbar selects
// Rev 1.0
// ============================================================================
module xbar_ctrl_pipe #(
  parameter int NUM_PORT     = 5,
  parameter int LOG_NUM_PORT = 3,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  xbar_ctrl_pipe_if.slave bus
);
  typedef logic [LOG_NUM_PORT-1:0] sel_t;
  typedef logic [CNT_W-1:0]        cnt_t;

  localparam sel_t IDLE    = {LOG_NUM_PORT{1'b1}};
  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

  sel_t [NUM_PORT-1:0] dec_out_sel;
  sel_t [NUM_PORT-1:0] dec_in_sel;
  logic [NUM_PORT-1:0] dec_in_valid;
  logic                row_err;
  logic                col_err;
  logic                alloc_ready_w;
  logic                accept;
  logic                rel;

  logic                out_valid_d,    out_valid_q;
  sel_t [NUM_PORT-1:0] out_sel_d,      out_sel_q;
  sel_t [NUM_PORT-1:0] in_sel_d,       in_sel_q;
  logic [NUM_PORT-1:0] in_sel_valid_d, in_sel_valid_q;
  logic                conflict_d,     conflict_q;
  logic                sticky_d,       sticky_q;
  cnt_t [NUM_PORT-1:0] cnt_d,          cnt_q;

  // Row decode: descending scan so the lowest set bit is the last write.
  always_comb begin
    row_err = 1'b0;
    for (int j = 0; j < NUM_PORT; j++) begin
      dec_out_sel[j] = IDLE;
      for (int i = NUM_PORT - 1; i >= 0; i--) begin
        if (bus.alloc_vector[j*NUM_PORT + i]) dec_out_sel[j] = sel_t'(i);
      end
      if ((bus.alloc_vector[j*NUM_PORT +: NUM_PORT] &
           (bus.alloc_vector[j*NUM_PORT +: NUM_PORT] - 1'b1)) != '0) row_err = 1'b1;
    end
  end

  // Column decode: IDLE never matches a real output index, so idle rows drop out.
  always_comb begin
    col_err = 1'b0;
    for (int i = 0; i < NUM_PORT; i++) begin
      dec_in_sel[i]   = IDLE;
      dec_in_valid[i] = 1'b0;
      for (int j = 0; j < NUM_PORT; j++) begin
        if (dec_out_sel[j] == sel_t'(i)) begin
          if (dec_in_valid[i]) begin
            col_err = 1'b1;
          end else begin
            dec_in_sel[i]   = sel_t'(j);
            dec_in_valid[i] = 1'b1;
          end
        end
      end
    end
  end

  assign alloc_ready_w = ~out_valid_q | bus.out_ready;
  assign accept        = bus.alloc_valid & alloc_ready_w;
  assign rel           = out_valid_q & bus.out_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_sel_d      = out_sel_q;
    in_sel_d       = in_sel_q;
    in_sel_valid_d = in_sel_valid_q;
    conflict_d     = conflict_q;
    sticky_d       = sticky_q;
    cnt_d          = cnt_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      out_sel_d      = dec_out_sel;
      in_sel_d       = dec_in_sel;
      in_sel_valid_d = dec_in_valid;
      conflict_d     = row_err | col_err;
    end else if (rel) begin
      out_valid_d    = 1'b0;
    end
    if (accept && (row_err || col_err)) sticky_d = 1'b1;
    else if (bus.err_clear)             sticky_d = 1'b0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (bus.count_clear) cnt_d[i] = '0;
      else if (accept && dec_in_valid[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_sel_q      <= {NUM_PORT{IDLE}};
      in_sel_q       <= {NUM_PORT{IDLE}};
      in_sel_valid_q <= '0;
      conflict_q     <= 1'b0;
      sticky_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_sel_q      <= out_sel_d;
      in_sel_q       <= in_sel_d;
      in_sel_valid_q <= in_sel_valid_d;
      conflict_q     <= conflict_d;
      sticky_q       <= sticky_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.alloc_ready       = alloc_ready_w;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_sel_vector    = out_sel_q;
  assign bus.in_sel_vector     = in_sel_q;
  assign bus.in_sel_valid      = in_sel_valid_q;
  assign bus.conflict          = conflict_q;
  assign bus.conflict_sticky   = sticky_q;
  assign bus.trav_count_vector = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_xbar_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// tb_xbar_ctrl_pipe : vector table, corner sequences and randomized model check
// Rev 1.0
// ============================================================================
module tb_xbar_ctrl_pipe;
  localparam int NP = 5;
  localparam int LP = 3;
  localparam int CW = 4;

  typedef struct packed {
    logic [NP*NP-1:0] vec;
    logic [NP*LP-1:0] osel;
    logic [NP*LP-1:0] isel;
    logic [NP-1:0]    iv;
    logic             conf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  xbar_ctrl_pipe_if #(.NUM_PORT(NP), .LOG_NUM_PORT(LP), .CNT_W(CW)) bus ();
  xbar_ctrl_pipe #(.NUM_PORT(NP), .LOG_NUM_PORT(LP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Reference state
  logic             m_valid, m_conf, m_sticky;
  logic [NP*LP-1:0] m_osel, m_isel;
  logic [NP-1:0]    m_iv;
  int               m_cnt[NP];

  function automatic void ref_decode(input logic [NP*NP-1:0] v,
                                     output logic [NP*LP-1:0] osel,
                                     output logic [NP*LP-1:0] isel,
                                     output logic [NP-1:0] iv,
                                     output logic err);
    int dest[NP];
    int q[$];
    logic [NP-1:0] row, low;
    err = 1'b0; osel = '1; isel = '1; iv = '0;
    for (int j = 0; j < NP; j++) begin
      row = v[j*NP +: NP];
      low = row & (~row + 5'd1);
      dest[j] = (row == '0) ? -1 : $clog2(low);
      if ($countones(row) > 1) err = 1'b1;
      if (dest[j] >= 0) osel[j*LP +: LP] = LP'(dest[j]);
    end
    for (int i = 0; i < NP; i++) begin
      q = {};
      for (int j = 0; j < NP; j++) if (dest[j] == i) q.push_back(j);
      if (q.size() > 0) begin isel[i*LP +: LP] = LP'(q[0]); iv[i] = 1'b1; end
      if (q.size() > 1) err = 1'b1;
    end
  endfunction

  task automatic model_update();
    logic ready, acc, rel, err;
    logic [NP*LP-1:0] os, is;
    logic [NP-1:0] iv;
    if (reset) begin
      m_valid = 0; m_conf = 0; m_sticky = 0; m_osel = '1; m_isel = '1; m_iv = '0;
      for (int i = 0; i < NP; i++) m_cnt[i] = 0;
      return;
    end
    ready = !m_valid || bus.out_ready;
    acc   = bus.alloc_valid && ready;
    rel   = m_valid && bus.out_ready;
    ref_decode(bus.alloc_vector, os, is, iv, err);
    if (acc) begin
      m_valid = 1; m_osel = os; m_isel = is; m_iv = iv; m_conf = err;
    end else if (rel) begin
      m_valid = 0;
    end
    if (acc && err) m_sticky = 1;
    else if (bus.err_clear) m_sticky = 0;
    for (int i = 0; i < NP; i++) begin
      if (bus.count_clear) m_cnt[i] = 0;
      else if (acc && iv[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NP*CW-1:0] cexp;
    for (int i = 0; i < NP; i++) cexp[i*CW +: CW] = CW'(m_cnt[i]);
    cmp({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
    cmp({tag, ".alloc_ready"}, 64'(bus.alloc_ready), 64'(!m_valid || bus.out_ready));
    cmp({tag, ".out_sel"}, 64'(bus.out_sel_vector), 64'(m_osel));
    cmp({tag, ".in_sel"}, 64'(bus.in_sel_vector), 64'(m_isel));
    cmp({tag, ".in_sel_valid"}, 64'(bus.in_sel_valid), 64'(m_iv));
    cmp({tag, ".conflict"}, 64'(bus.conflict), 64'(m_conf));
    cmp({tag, ".sticky"}, 64'(bus.conflict_sticky), 64'(m_sticky));
    cmp({tag, ".counters"}, 64'(bus.trav_count_vector), 64'(cexp));
  endtask

  task automatic tick(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic av, input logic [NP*NP-1:0] v, input logic ordy,
                       input logic ec, input logic cc);
    bus.alloc_valid  = av;
    bus.alloc_vector = v;
    bus.out_ready    = ordy;
    bus.err_clear    = ec;
    bus.count_clear  = cc;
  endtask

  function automatic logic [NP-1:0] rand_row();
    case ($urandom_range(0, 3))
      0:       return '0;
      1, 2:    return NP'(1) << $urandom_range(0, NP - 1);
      default: return NP'($urandom_range(0, (1 << NP) - 1));
    endcase
  endfunction

  vec_t tbl[6];
  logic [NP*NP-1:0] rv;

  initial begin
    tbl[0] = '{vec: {5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b00010},
               osel: {3'd0, 3'd4, 3'd3, 3'd2, 3'd1},
               isel: {3'd3, 3'd2, 3'd1, 3'd0, 3'd4}, iv: 5'b11111, conf: 1'b0};
    tbl[1] = '{vec: {5'b0, 5'b00100, 5'b0, 5'b00100, 5'b0},
               osel: {3'd7, 3'd2, 3'd7, 3'd2, 3'd7},
               isel: {3'd7, 3'd7, 3'd1, 3'd7, 3'd7}, iv: 5'b00100, conf: 1'b1};
    tbl[2] = '{vec: {5'b0, 5'b0, 5'b0, 5'b0, 5'b00110},
               osel: {3'd7, 3'd7, 3'd7, 3'd7, 3'd1},
               isel: {3'd7, 3'd7, 3'd7, 3'd0, 3'd7}, iv: 5'b00010, conf: 1'b1};
    tbl[3] = '{vec: '0, osel: '1, isel: '1, iv: 5'b00000, conf: 1'b0};
    tbl[4] = '{vec: {5{5'b00001}}, osel: '0,
               isel: {3'd7, 3'd7, 3'd7, 3'd7, 3'd0}, iv: 5'b00001, conf: 1'b1};
    tbl[5] = '{vec: {5'b0, 5'b0, 5'b11111, 5'b0, 5'b0},
               osel: {3'd7, 3'd7, 3'd0, 3'd7, 3'd7},
               isel: {3'd7, 3'd7, 3'd7, 3'd7, 3'd2}, iv: 5'b00001, conf: 1'b1};

    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick("rst0");
    tick("rst1");
    reset = 1'b0;
    tick("idle");
    cmp("reset_out_sel_idle", 64'(bus.out_sel_vector), 64'({NP*LP{1'b1}}));
    cmp("reset_alloc_ready", 64'(bus.alloc_ready), 64'd1);

    // Table vectors, back-to-back accepts
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, tbl[k].vec, 1'b1, 1'b0, 1'b0);
      tick("tbl");
      cmp("tbl_out_sel", 64'(bus.out_sel_vector), 64'(tbl[k].osel));
      cmp("tbl_in_sel", 64'(bus.in_sel_vector), 64'(tbl[k].isel));
      cmp("tbl_in_valid", 64'(bus.in_sel_valid), 64'(tbl[k].iv));
      cmp("tbl_conflict", 64'(bus.conflict), 64'(tbl[k].conf));
      cmp("tbl_out_valid", 64'(bus.out_valid), 64'd1);
    end

    // Sticky clear, then error and clear together
    drive(1'b1, tbl[0].vec, 1'b1, 1'b1, 1'b0);
    tick("clr");
    cmp("sticky_cleared", 64'(bus.conflict_sticky), 64'd0);
    drive(1'b1, tbl[1].vec, 1'b1, 1'b1, 1'b0);
    tick("set_wins");
    cmp("sticky_set_wins", 64'(bus.conflict_sticky), 64'd1);

    // Backpressure: entry must hold for 3 cycles, then load with no bubble
    drive(1'b1, tbl[2].vec, 1'b1, 1'b0, 1'b0);
    tick("bp_load");
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, tbl[0].vec, 1'b0, 1'b0, 1'b0);
      #1;
      cmp("bp_alloc_ready", 64'(bus.alloc_ready), 64'd0);
      tick("bp_hold");
      cmp("bp_out_sel_hold", 64'(bus.out_sel_vector), 64'(tbl[2].osel));
    end
    drive(1'b1, tbl[0].vec, 1'b1, 1'b0, 1'b0);
    tick("bp_release");
    cmp("bp_no_bubble_valid", 64'(bus.out_valid), 64'd1);
    cmp("bp_no_bubble_sel", 64'(bus.out_sel_vector), 64'(tbl[0].osel));

    // Saturation of counter 2, then clear alongside an accept
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, tbl[1].vec, 1'b1, 1'b0, 1'b0);
      tick("sat");
    end
    cmp("sat_cnt2", 64'(bus.trav_count_vector[2*CW +: CW]), 64'd15);
    drive(1'b1, tbl[0].vec, 1'b1, 1'b0, 1'b1);
    tick("cnt_clr");
    cmp("cnt_clear_wins", 64'(bus.trav_count_vector), 64'd0);

    // Reset while an entry is held
    drive(1'b1, tbl[1].vec, 1'b1, 1'b0, 1'b0);
    tick("pre_rst");
    drive(1'b1, tbl[0].vec, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick("mid_rst");
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cmp("midrst_valid", 64'(bus.out_valid), 64'd0);
    cmp("midrst_sel", 64'(bus.in_sel_vector), 64'({NP*LP{1'b1}}));
    cmp("midrst_sticky", 64'(bus.conflict_sticky), 64'd0);
    tick("post_rst");

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      for (int j = 0; j < NP; j++) rv[j*NP +: NP] = rand_row();
      drive(1'($urandom_range(0, 3) != 0), rv, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
